// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt arbiter.
//  - intr_state_e : dispatch FSM states (2-bit, encoding also visible in STATUS[1:0])
//  - OFS_*        : register word offsets, added to NUM_SRC to form the address
//                   of the registers that follow the PRIO[] array.
package intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_GRANT   = 2'd2,
        ST_SERVICE = 2'd3
    } intr_state_e;

    localparam int OFS_ENABLE  = 0;
    localparam int OFS_PENDING = 1;
    localparam int OFS_STATUS  = 2;

endpackage

// File: rtl/intr_prio_sel.sv
// Combinational winner selection over the eligible sources.
// Picks the highest priority; among equal priorities the first index at or
// after rr_ptr (wrapping) wins.
// Ports:
//  eligible  in  NUM_SRC          sources allowed to win
//  prio_tbl  in  NUM_SRC x PRIO_W per-source priority
//  rr_ptr    in  ID_W             round-robin start index
//  found     out 1                at least one eligible source
//  id        out ID_W             winning index
//  prio      out PRIO_W           winning priority
module intr_prio_sel #(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = $clog2(NUM_SRC),
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]             eligible,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_tbl,
    input  logic [ID_W-1:0]                rr_ptr,
    output logic                           found,
    output logic [ID_W-1:0]                id,
    output logic [PRIO_W-1:0]              prio
);

    localparam logic [ID_W:0] NUM_W = (ID_W+1)'(NUM_SRC);

    logic [ID_W:0]   idx_wide;
    logic [ID_W-1:0] idx;

    // Scan starting at rr_ptr; only a strictly greater priority replaces the
    // current best, so the first hit in rotated order wins a tie.
    always_comb begin
        found    = 1'b0;
        id       = '0;
        prio     = '0;
        idx_wide = '0;
        idx      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx_wide = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx_wide >= NUM_W) begin
                idx_wide = idx_wide - NUM_W;
            end
            idx = idx_wide[ID_W-1:0];
            if (eligible[idx] && (!found || (prio_tbl[idx] > prio))) begin
                found = 1'b1;
                id    = idx;
                prio  = prio_tbl[idx];
            end
        end
    end

endmodule

// File: rtl/intr_arbiter.sv
// APB-configured interrupt arbiter. Rising edges on intr_req_i are latched
// into PENDING; enabled, non-zero-priority pending sources are dispatched one
// at a time over a valid/ack/done handshake.
// Handshake: intr_valid_o rises with id/prio and holds them until intr_ack_i;
// the ack clears that source's pending bit; the CPU then raises intr_done_i
// once servicing ends, after which the next dispatch may start.
// Ports:
//  pclk, prst_n                        clock, async active-low reset
//  psel/penable/pwrite/paddr/pwdata    APB request
//  prdata/pready/pslverr               APB response (zero wait state)
//  intr_req_i                          edge-sensitive request lines
//  intr_valid_o/intr_id_o/intr_prio_o  dispatch to CPU
//  intr_ack_i/intr_done_i              CPU accept / service complete
module intr_arbiter
    import intr_pkg::*;
#(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = $clog2(NUM_SRC),
    parameter int ID_W    = $clog2(NUM_SRC),
    parameter int ADDR_W  = $clog2(NUM_SRC) + 1
) (
    input  logic               pclk,
    input  logic               prst_n,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [ADDR_W-1:0]  paddr,
    input  logic [NUM_SRC-1:0] pwdata,
    output logic [NUM_SRC-1:0] prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [NUM_SRC-1:0] intr_req_i,
    output logic               intr_valid_o,
    output logic [ID_W-1:0]    intr_id_o,
    output logic [PRIO_W-1:0]  intr_prio_o,
    input  logic               intr_ack_i,
    input  logic               intr_done_i
);

    localparam logic [ADDR_W-1:0] A_ENABLE  = ADDR_W'(NUM_SRC + OFS_ENABLE);
    localparam logic [ADDR_W-1:0] A_PENDING = ADDR_W'(NUM_SRC + OFS_PENDING);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(NUM_SRC + OFS_STATUS);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_SRC - 1);

    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q;
    logic [NUM_SRC-1:0] enable_q, pending_q, req_q;
    logic [NUM_SRC-1:0] pending_d, w1c_mask, ack_clr, eligible;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, id_q, id_d, sel_id;
    logic [PRIO_W-1:0]  prio_out_q, prio_d, sel_prio;
    logic               valid_q, valid_d, sel_found;
    logic               access, wr, rd, is_prio, mapped;
    logic [ID_W+1:0]    status_w;
    intr_state_e        state_q, state_d;

    // ---------------- APB decode ----------------
    assign access   = psel & penable;
    assign wr       = access & pwrite;
    assign rd       = access & ~pwrite;
    assign is_prio  = (paddr < A_ENABLE);
    assign mapped   = is_prio | (paddr == A_ENABLE) | (paddr == A_PENDING) | (paddr == A_STATUS);
    assign pready   = access;
    assign pslverr  = access & ~mapped;
    assign status_w = {rr_ptr_q, state_q};

    always_comb begin
        prdata = '0;
        if (rd) begin
            if (is_prio)                 prdata = NUM_SRC'(prio_q[paddr[ID_W-1:0]]);
            else if (paddr == A_ENABLE)  prdata = enable_q;
            else if (paddr == A_PENDING) prdata = pending_q;
            else if (paddr == A_STATUS)  prdata = NUM_SRC'(status_w);
        end
    end

    // ---------------- pending / eligibility ----------------
    assign w1c_mask = (wr && (paddr == A_PENDING)) ? pwdata : '0;

    // A new edge is OR-ed in after the clears so it survives a same-cycle clear.
    assign pending_d = (pending_q & ~(w1c_mask | ack_clr)) | (intr_req_i & ~req_q);

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i] != '0);
        end
    end

    intr_prio_sel #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_prio_sel (
        .eligible (eligible),
        .prio_tbl (prio_q),
        .rr_ptr   (rr_ptr_q),
        .found    (sel_found),
        .id       (sel_id),
        .prio     (sel_prio)
    );

    // ---------------- dispatch FSM: next state ----------------
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        id_d     = id_q;
        prio_d   = prio_out_q;
        rr_ptr_d = rr_ptr_q;
        ack_clr  = '0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) state_d = ST_ARB;
            end
            ST_ARB: begin
                // Eligibility may have vanished (W1C) since IDLE saw it.
                if (sel_found) begin
                    id_d    = sel_id;
                    prio_d  = sel_prio;
                    valid_d = 1'b1;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (intr_ack_i) begin
                    valid_d  = 1'b0;
                    ack_clr  = NUM_SRC'(1) << id_q;
                    rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);
                    state_d  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (intr_done_i) state_d = (|eligible) ? ST_ARB : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            prio_q     <= '0;
            enable_q   <= '0;
            pending_q  <= '0;
            req_q      <= '0;
            rr_ptr_q   <= '0;
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            id_q       <= '0;
            prio_out_q <= '0;
        end else begin
            if (wr && is_prio)           prio_q[paddr[ID_W-1:0]] <= pwdata[PRIO_W-1:0];
            if (wr && paddr == A_ENABLE) enable_q <= pwdata;
            pending_q  <= pending_d;
            req_q      <= intr_req_i;
            rr_ptr_q   <= rr_ptr_d;
            state_q    <= state_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            prio_out_q <= prio_d;
        end
    end

    assign intr_valid_o = valid_q;
    assign intr_id_o    = id_q;
    assign intr_prio_o  = prio_out_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// Bench for intr_arbiter: APB driver tasks, CPU-side service task, and a
// dispatch monitor that pops {id,prio} expectations from exp_q.
module tb_intr_arbiter;

    localparam int NUM_SRC = 16;
    localparam int PRIO_W  = 4;
    localparam int ID_W    = 4;
    localparam int ADDR_W  = 5;
    localparam int A_ENABLE  = 16;
    localparam int A_PENDING = 17;
    localparam int A_STATUS  = 18;
    localparam int A_BAD     = 19;

    // ---------------- clock / reset ----------------
    logic pclk = 1'b0;
    logic prst_n = 1'b0;
    always #5 pclk = ~pclk;

    logic               psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [ADDR_W-1:0]  paddr = '0;
    logic [NUM_SRC-1:0] pwdata = '0;
    logic [NUM_SRC-1:0] prdata;
    logic               pready, pslverr;
    logic [NUM_SRC-1:0] intr_req_i = '0;
    logic               intr_valid_o;
    logic [ID_W-1:0]    intr_id_o;
    logic [PRIO_W-1:0]  intr_prio_o;
    logic               intr_ack_i = 1'b0, intr_done_i = 1'b0;

    intr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .pclk         (pclk),
        .prst_n       (prst_n),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .intr_req_i   (intr_req_i),
        .intr_valid_o (intr_valid_o),
        .intr_id_o    (intr_id_o),
        .intr_prio_o  (intr_prio_o),
        .intr_ack_i   (intr_ack_i),
        .intr_done_i  (intr_done_i)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [ID_W+PRIO_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ID_W+PRIO_W-1:0] disp(input int id, input int prio);
        return {ID_W'(id), PRIO_W'(prio)};
    endfunction

    // Monitor: each new dispatch pops one expectation; while valid stays high
    // id/prio must not move.
    logic            prev_valid = 1'b0;
    logic [ID_W-1:0] held_id = '0;
    logic [PRIO_W-1:0] held_prio = '0;

    always @(negedge pclk) begin : monitor
        logic [ID_W+PRIO_W-1:0] e;
        if (!prst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (intr_valid_o && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dispatch: got id=%0d prio=%0d, required no dispatch",
                             intr_id_o, intr_prio_o);
                end else begin
                    e = exp_q.pop_front();
                    check("dispatch_id", 32'(intr_id_o), 32'(e[ID_W+PRIO_W-1:PRIO_W]));
                    check("dispatch_prio", 32'(intr_prio_o), 32'(e[PRIO_W-1:0]));
                end
                held_id   = intr_id_o;
                held_prio = intr_prio_o;
            end else if (intr_valid_o && prev_valid) begin
                check("grant_stable_id", 32'(intr_id_o), 32'(held_id));
                check("grant_stable_prio", 32'(intr_prio_o), 32'(held_prio));
            end
            prev_valid = intr_valid_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        intr_req_i  = '0;
        intr_ack_i  = 1'b0;
        intr_done_i = 1'b0;
        prst_n = 1'b0;
        repeat (2) @(posedge pclk);
        #1 prst_n = 1'b1;
    endtask

    task automatic apb_write(input int addr, input logic [NUM_SRC-1:0] data, input logic exp_err);
        @(posedge pclk);
        #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = ADDR_W'(addr); pwdata = data;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        check("pready_wr", 32'(pready), 32'd1);
        check("pslverr_wr", 32'(pslverr), 32'(exp_err));
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read_check(input string name, input int addr,
                                  input logic [NUM_SRC-1:0] exp_data, input logic exp_err);
        @(posedge pclk);
        #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = ADDR_W'(addr);
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        check(name, 32'(prdata), 32'(exp_data));
        check("pready_rd", 32'(pready), 32'd1);
        check("pslverr_rd", 32'(pslverr), 32'(exp_err));
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic pulse_req(input logic [NUM_SRC-1:0] mask);
        @(posedge pclk);
        #1 intr_req_i = mask;
        @(posedge pclk);
        #1 intr_req_i = '0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20; i++) begin
            if (intr_valid_o) break;
            @(negedge pclk);
        end
        check(name, 32'(intr_valid_o), 32'd1);
    endtask

    // Accept the current dispatch and finish servicing it.
    task automatic service();
        wait_valid("wait_valid");
        repeat (2) @(posedge pclk);
        #1 intr_ack_i = 1'b1;
        @(posedge pclk);
        #1 intr_ack_i = 1'b0;
        @(negedge pclk);
        check("valid_drop_after_ack", 32'(intr_valid_o), 32'd0);
        @(posedge pclk);
        #1 intr_done_i = 1'b1;
        @(posedge pclk);
        #1 intr_done_i = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        do_reset();

        // Reset state
        @(negedge pclk);
        check("rst_valid", 32'(intr_valid_o), 32'd0);
        check("rst_id", 32'(intr_id_o), 32'd0);
        check("rst_prio", 32'(intr_prio_o), 32'd0);
        apb_read_check("rst_enable", A_ENABLE, 16'h0000, 1'b0);
        apb_read_check("rst_pending", A_PENDING, 16'h0000, 1'b0);
        apb_read_check("rst_status", A_STATUS, 16'h0000, 1'b0);

        // Register access and unmapped address
        apb_write(1, 16'h0003, 1'b0);
        apb_read_check("prio1_rd", 1, 16'h0003, 1'b0);
        apb_write(1, 16'hFFFF, 1'b0);
        apb_read_check("prio1_upper_zero", 1, 16'h000F, 1'b0);
        apb_write(1, 16'h0000, 1'b0);
        apb_read_check("bad_addr_rd", A_BAD, 16'h0000, 1'b1);
        apb_write(A_BAD, 16'hFFFF, 1'b1);
        apb_read_check("prio15_after_bad_wr", 15, 16'h0000, 1'b0);

        // Max priority wins, checked with the two-cycle dispatch latency
        apb_write(3, 16'd5, 1'b0);
        apb_write(9, 16'd12, 1'b0);
        apb_write(A_ENABLE, 16'hFFFF, 1'b0);
        exp_q.push_back(disp(9, 12));
        exp_q.push_back(disp(3, 5));
        pulse_req(16'h0208);
        @(negedge pclk);
        check("latency_k", 32'(intr_valid_o), 32'd0);
        @(negedge pclk);
        check("latency_k1", 32'(intr_valid_o), 32'd0);
        @(negedge pclk);
        check("latency_k2", 32'(intr_valid_o), 32'd1);
        service();
        service();
        repeat (3) @(posedge pclk);

        // Round-robin among equal priorities, then wrap from rr_ptr=13
        do_reset();
        apb_write(2, 16'd7, 1'b0);
        apb_write(6, 16'd7, 1'b0);
        apb_write(12, 16'd7, 1'b0);
        apb_write(A_ENABLE, 16'hFFFF, 1'b0);
        exp_q.push_back(disp(2, 7));
        exp_q.push_back(disp(6, 7));
        exp_q.push_back(disp(12, 7));
        pulse_req(16'h1044);
        service();
        service();
        service();
        repeat (3) @(posedge pclk);
        // Stray ack/done in IDLE must not move state or rr_ptr
        #1 intr_ack_i = 1'b1; intr_done_i = 1'b1;
        @(posedge pclk);
        #1 intr_ack_i = 1'b0; intr_done_i = 1'b0;
        apb_read_check("status_rr13_idle", A_STATUS, 16'h0034, 1'b0);
        exp_q.push_back(disp(2, 7));
        exp_q.push_back(disp(6, 7));
        exp_q.push_back(disp(12, 7));
        pulse_req(16'h1044);
        service();
        service();
        service();
        repeat (3) @(posedge pclk);
        apb_read_check("pending_after_rr", A_PENDING, 16'h0000, 1'b0);

        // Disabled source stays pending until enabled
        apb_write(4, 16'd15, 1'b0);
        apb_write(A_ENABLE, 16'hFFEF, 1'b0);
        pulse_req(16'h0010);
        repeat (4) @(negedge pclk);
        check("masked_no_valid", 32'(intr_valid_o), 32'd0);
        apb_read_check("masked_pending", A_PENDING, 16'h0010, 1'b0);
        exp_q.push_back(disp(4, 15));
        apb_write(A_ENABLE, 16'hFFFF, 1'b0);
        begin : enable_wait
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge pclk);
                if (intr_valid_o) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("enable_latency", 32'(seen), 32'd1);
        end
        service();
        repeat (3) @(posedge pclk);

        // W1C racing a new edge on the same line: the set wins
        apb_write(A_ENABLE, 16'h0000, 1'b0);
        pulse_req(16'h0020);
        apb_read_check("pend5_set", A_PENDING, 16'h0020, 1'b0);
        @(posedge pclk);
        #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = ADDR_W'(A_PENDING); pwdata = 16'h0020;
        @(posedge pclk);
        #1 penable = 1'b1; intr_req_i = 16'h0020;
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; intr_req_i = '0;
        apb_read_check("w1c_race_keeps", A_PENDING, 16'h0020, 1'b0);
        apb_write(A_PENDING, 16'h0020, 1'b0);
        apb_read_check("w1c_clears", A_PENDING, 16'h0000, 1'b0);

        // Asynchronous reset in the middle of a grant
        apb_write(7, 16'd9, 1'b0);
        apb_write(A_ENABLE, 16'hFFFF, 1'b0);
        exp_q.push_back(disp(7, 9));
        pulse_req(16'h0080);
        wait_valid("mid_grant_valid");
        #2 prst_n = 1'b0;
        #1;
        check("arst_valid", 32'(intr_valid_o), 32'd0);
        check("arst_id", 32'(intr_id_o), 32'd0);
        check("arst_prio", 32'(intr_prio_o), 32'd0);
        repeat (2) @(posedge pclk);
        #1 prst_n = 1'b1;
        apb_read_check("arst_pending", A_PENDING, 16'h0000, 1'b0);
        apb_read_check("arst_enable", A_ENABLE, 16'h0000, 1'b0);

        repeat (4) @(posedge pclk);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
